// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid defaults, food FSM states, width helper
// and the Galois LFSR tap table used by every LFSR instance in the game.
package snake_pkg;

    localparam int GRID_W_DEF = 64;
    localparam int GRID_H_DEF = 48;
    localparam int CELL_DEF   = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DRAW  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so a 1-wide grid still gets a 1-bit index.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) w = w + 1;
        return w;
    endfunction

    // Maximal-length Galois tap masks (right-shifting form); 0 = width unsupported.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] t;
        case (width)
            4:       t = 64'h9;
            5:       t = 64'h12;
            6:       t = 64'h21;
            7:       t = 64'h41;
            8:       t = 64'hB8;
            10:      t = 64'h240;
            12:      t = 64'hE08;
            16:      t = 64'hB400;
            20:      t = 64'h90000;
            24:      t = 64'hE10000;
            32:      t = 64'h80200003;
            default: t = 64'h0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR. Steps on every clock edge after reset release,
// regardless of what the consumer is doing, so draws decorrelate over time.
module lfsr_gen
    import snake_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    if (TAPS == '0) begin : g_bad_width
        $error("lfsr_gen: no tap entry for this LFSR_W");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero (all-zero state locks up)");
    end

    // Shift right; when the bit falling out is 1, fold the tap mask back in.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            q <= SEED;
        end else if (q[0]) begin
            q <= (q >> 1) ^ TAPS;
        end else begin
            q <= q >> 1;
        end
    end

endmodule

// File: rtl/food_spawner.sv
// Food placement for the snake game: reject-samples grid cells from the LFSR,
// falls back to a deterministic walk after too many rejects, and respawns when
// the head lands on the food or on a spawn request.
//
// Handshake: spawn_req is a level request sampled only in EMPTY and HOLD (ignored
// while busy); food_valid marks food_x/food_y as a placed cell and stays high until
// the food is eaten or respawned; eaten is a single-cycle strobe with no back-pressure.
module food_spawner
    import snake_pkg::*;
#(
    parameter int                GRID_W    = GRID_W_DEF,
    parameter int                GRID_H    = GRID_H_DEF,
    parameter int                CELL      = CELL_DEF,
    parameter int                X_W       = 10,
    parameter int                Y_W       = 9,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int                MAX_TRIES = 15
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [X_W-1:0]    snake_x,
    input  logic [Y_W-1:0]    snake_y,
    input  logic              spawn_req,
    output logic [X_W-1:0]    food_x,
    output logic [Y_W-1:0]    food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              eaten,
    output state_t            state_dbg,
    output logic [LFSR_W-1:0] lfsr_dbg
);

    localparam int CW = clog2(GRID_W);
    localparam int RW = clog2(GRID_H);
    localparam int TW = clog2(MAX_TRIES + 1);

    localparam logic [CW:0]     COL_LIM   = (CW + 1)'(GRID_W);
    localparam logic [RW:0]     ROW_LIM   = (RW + 1)'(GRID_H);
    localparam logic [CW-1:0]   COL_LAST  = CW'(GRID_W - 1);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(GRID_H - 1);
    localparam logic [X_W-1:0]  CELL_X    = X_W'(CELL);
    localparam logic [Y_W-1:0]  CELL_Y    = Y_W'(CELL);
    localparam logic [TW-1:0]   TRIES_MAX = TW'(MAX_TRIES);

    if (GRID_W < 1 || GRID_H < 1 || longint'(GRID_W) > (longint'(1) << LFSR_W)) begin : g_bad_grid
        $error("food_spawner: grid size out of range");
    end
    if (longint'(GRID_W) * longint'(CELL) > (longint'(1) << X_W)) begin : g_bad_x
        $error("food_spawner: GRID_W*CELL does not fit in X_W");
    end
    if (longint'(GRID_H) * longint'(CELL) > (longint'(1) << Y_W)) begin : g_bad_y
        $error("food_spawner: GRID_H*CELL does not fit in Y_W");
    end
    if (CW + RW > LFSR_W) begin : g_bad_lfsr
        $error("food_spawner: LFSR too narrow for column+row index");
    end

    function automatic logic [X_W-1:0] col_px(input logic [CW-1:0] c);
        return X_W'(c) * CELL_X;
    endfunction

    function automatic logic [Y_W-1:0] row_px(input logic [RW-1:0] r);
        return Y_W'(r) * CELL_Y;
    endfunction

    // Raster-order successor: next column, wrapping to column 0 of the next row,
    // and from the last row back to row 0.
    function automatic logic [CW+RW-1:0] next_cell(input logic [CW-1:0] c, input logic [RW-1:0] r);
        logic [CW-1:0] nc;
        logic [RW-1:0] nr;
        nc = c + 1'b1;
        nr = r;
        if (c == COL_LAST) begin
            nc = '0;
            nr = (r == ROW_LAST) ? '0 : r + 1'b1;
        end
        return {nr, nc};
    endfunction

    state_t            state, state_n;
    logic [TW-1:0]     tries, tries_n;
    logic [CW-1:0]     food_col, load_col, cand_col, fb_col;
    logic [RW-1:0]     food_row, load_row, cand_row, fb_row;
    logic [CW+RW-1:0]  step1, step2;
    logic [LFSR_W-1:0] lfsr_q;
    logic              load, cand_ok, food_hit;

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .q        (lfsr_q)
    );

    assign cand_col = lfsr_q[CW-1:0];
    assign cand_row = lfsr_q[CW+RW-1:CW];
    assign cand_ok  = ({1'b0, cand_col} < COL_LIM) && ({1'b0, cand_row} < ROW_LIM) &&
                      !((col_px(cand_col) == snake_x) && (row_px(cand_row) == snake_y));
    assign food_hit = (food_x == snake_x) && (food_y == snake_y);

    // Fallback cell: successor of the current food cell, skipping the head once.
    always_comb begin
        step1 = next_cell(food_col, food_row);
        step2 = next_cell(step1[CW-1:0], step1[CW+RW-1:CW]);
        if ((col_px(step1[CW-1:0]) == snake_x) && (row_px(step1[CW+RW-1:CW]) == snake_y)) begin
            {fb_row, fb_col} = step2;
        end else begin
            {fb_row, fb_col} = step1;
        end
    end

    // Next-state, retry counter and load decision; eaten is a Mealy strobe in HOLD.
    always_comb begin
        state_n  = state;
        tries_n  = tries;
        load     = 1'b0;
        load_col = cand_col;
        load_row = cand_row;
        eaten    = 1'b0;
        case (state)
            EMPTY: begin
                if (spawn_req) state_n = DRAW;
            end
            DRAW: begin
                if (tries == TRIES_MAX) begin
                    load     = 1'b1;
                    load_col = fb_col;
                    load_row = fb_row;
                    tries_n  = '0;
                    state_n  = HOLD;
                end else if (cand_ok) begin
                    load    = 1'b1;
                    tries_n = '0;
                    state_n = HOLD;
                end else begin
                    tries_n = tries + 1'b1;
                end
            end
            HOLD: begin
                if (food_hit) begin
                    eaten   = 1'b1;
                    state_n = DRAW;
                end else if (spawn_req) begin
                    state_n = DRAW;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // State and retry counter registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
            tries <= '0;
        end else begin
            state <= state_n;
            tries <= tries_n;
        end
    end

    // Food position registers; they keep the last cell while no food is valid.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            food_col <= '0;
            food_row <= '0;
            food_x   <= '0;
            food_y   <= '0;
        end else if (load) begin
            food_col <= load_col;
            food_row <= load_row;
            food_x   <= col_px(load_col);
            food_y   <= row_px(load_row);
        end
    end

    assign food_valid = (state == HOLD);
    assign busy       = (state == DRAW);
    assign state_dbg  = state;
    assign lfsr_dbg   = lfsr_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: A = default 64x48 grid, B = 3x2 grid, C = MAX_TRIES=0
// (every draw takes the deterministic fallback walk).
module tb_food_spawner;
    import snake_pkg::*;

    localparam int          X_W      = 10;
    localparam int          Y_W      = 9;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [15:0] TAPS_REF = 16'hB400;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    // ---------------- DUT signals ----------------
    logic [X_W-1:0] hx_a, hx_b, hx_c, fx_a, fx_b, fx_c;
    logic [Y_W-1:0] hy_a, hy_b, hy_c, fy_a, fy_b, fy_c;
    logic           spawn_a, spawn_b, spawn_c;
    logic           fv_a, fv_b, fv_c, busy_a, busy_b, busy_c, eaten_a, eaten_b, eaten_c;
    state_t         st_a, st_b, st_c;
    logic [15:0]    lfsr_a, lfsr_b, lfsr_c;

    food_spawner u_a (
        .CLOCK_50(clk), .resetn(rst_a), .snake_x(hx_a), .snake_y(hy_a), .spawn_req(spawn_a),
        .food_x(fx_a), .food_y(fy_a), .food_valid(fv_a), .busy(busy_a), .eaten(eaten_a),
        .state_dbg(st_a), .lfsr_dbg(lfsr_a)
    );

    food_spawner #(.GRID_W(3), .GRID_H(2)) u_b (
        .CLOCK_50(clk), .resetn(rst_b), .snake_x(hx_b), .snake_y(hy_b), .spawn_req(spawn_b),
        .food_x(fx_b), .food_y(fy_b), .food_valid(fv_b), .busy(busy_b), .eaten(eaten_b),
        .state_dbg(st_b), .lfsr_dbg(lfsr_b)
    );

    food_spawner #(.MAX_TRIES(0)) u_c (
        .CLOCK_50(clk), .resetn(rst_c), .snake_x(hx_c), .snake_y(hy_c), .spawn_req(spawn_c),
        .food_x(fx_c), .food_y(fy_c), .food_valid(fv_c), .busy(busy_c), .eaten(eaten_c),
        .state_dbg(st_c), .lfsr_dbg(lfsr_c)
    );

    // ---------------- checking core ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference Galois LFSR for instance A.
    logic [15:0] lfsr_ref;
    logic        lfsr_chk_en = 1'b0;
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) lfsr_ref <= SEED;
        else        lfsr_ref <= lfsr_ref[0] ? ((lfsr_ref >> 1) ^ TAPS_REF) : (lfsr_ref >> 1);
    end
    always @(negedge clk) begin
        if (lfsr_chk_en) check("a_lfsr", lfsr_a, lfsr_ref);
    end

    // Event counters for instance A.
    int   eaten_cnt_a = 0;
    int   draw_ep_a   = 0;
    logic busy_prev_a = 1'b0;
    always @(negedge clk) begin
        if (eaten_a) eaten_cnt_a++;
        if (busy_a && !busy_prev_a) draw_ep_a++;
        busy_prev_a = busy_a;
    end

    // Scoreboard for instance C: expected food pushed at spawn, popped when food_valid rises.
    logic [X_W+Y_W-1:0] exp_q[$];
    logic               valid_prev_c = 1'b0;
    always @(negedge clk) begin
        logic [X_W+Y_W-1:0] e;
        if (fv_c && !valid_prev_c) begin
            check("c_sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("c_sb_food", {fx_c, fy_c}, e);
            end
        end
        valid_prev_c = fv_c;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spawn(input int which, input logic v);
        case (which)
            0:       spawn_a = v;
            1:       spawn_b = v;
            default: spawn_c = v;
        endcase
    endtask

    // Single-cycle spawn pulse, leaves the caller just after the sampling edge.
    task automatic pulse_spawn(input int which);
        tick();
        set_spawn(which, 1'b1);
        tick();
        set_spawn(which, 1'b0);
    endtask

    // Placement bound: up to MAX_TRIES+1 cycles in DRAW, then one negedge to see HOLD.
    task automatic wait_valid(input int which, input string name);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (n < 17 && !got) begin
            @(negedge clk);
            n++;
            case (which)
                0:       got = fv_a;
                1:       got = fv_b;
                default: got = fv_c;
            endcase
        end
        check(name, got, 1);
    endtask

    task automatic check_food_a();
        check("a_x_aligned", fx_a % 10, 0);
        check("a_y_aligned", fy_a % 10, 0);
        check("a_x_range", fx_a < 640, 1);
        check("a_y_range", fy_a < 480, 1);
        check("a_not_head", (fx_a == hx_a) && (fy_a == hy_a), 0);
    endtask

    task automatic spawn_c_expect(input int hx, input int hy, input int ex, input int ey);
        tick();
        hx_c = X_W'(hx);
        hy_c = Y_W'(hy);
        exp_q.push_back({X_W'(ex), Y_W'(ey)});
        spawn_c = 1'b1;
        tick();
        spawn_c = 1'b0;
        wait_valid(2, "c_valid_timeout");
    endtask

    function automatic void adv_cell(inout int c, inout int r);
        c++;
        if (c == 64) begin
            c = 0;
            r++;
            if (r == 48) r = 0;
        end
    endfunction

    // ---------------- stimulus table ----------------
    typedef struct {
        int hx;
        int hy;
        int ex;
        int ey;
    } vec_t;
    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        int   cur_c, cur_r, e0, d0, ok, col, row;
        logic [X_W-1:0] old_x;
        logic [Y_W-1:0] old_y;
        logic [5:0]     seen;

        // fallback walk from reset cell (0,0): head position, expected food
        vecs[0] = '{hx: 500, hy: 300, ex: 10, ey: 0};
        vecs[1] = '{hx: 20,  hy: 0,   ex: 30, ey: 0};   // successor is the head -> skip
        vecs[2] = '{hx: 0,   hy: 0,   ex: 40, ey: 0};
        vecs[3] = '{hx: 630, hy: 0,   ex: 50, ey: 0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        spawn_a = 1'b0; spawn_b = 1'b0; spawn_c = 1'b0;
        hx_a = 10'd300; hy_a = 9'd200;
        hx_b = '0;      hy_b = '0;
        hx_c = 10'd500; hy_c = 9'd300;
        #2;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        lfsr_chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_food_x", fx_a, 0);
        check("rst_food_y", fy_a, 0);
        check("rst_valid", fv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_eaten", eaten_a, 0);
        check("rst_state", st_a, EMPTY);
        check("rst_lfsr", lfsr_a, SEED);
        check("rst_state_c", st_c, EMPTY);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_valid", fv_a, 0);
        check("idle_state", st_a, EMPTY);

        // 1: first placement on the default grid
        pulse_spawn(0);
        check("a_busy_in_draw", busy_a, 1);
        wait_valid(0, "a_first_valid_timeout");
        check_food_a();

        // 2: head lands on the food
        e0 = eaten_cnt_a;
        tick();
        hx_a = fx_a;
        hy_a = fy_a;
        @(negedge clk);
        check("a_eaten_pulse", eaten_a, 1);
        @(negedge clk);
        check("a_eaten_drop", eaten_a, 0);
        check("a_valid_drop", fv_a, 0);
        wait_valid(0, "a_respawn_timeout");
        check_food_a();
        check("a_eaten_once", eaten_cnt_a - e0, 1);

        // 5: head hit and spawn_req together, spawn_req held into DRAW
        e0 = eaten_cnt_a;
        d0 = draw_ep_a;
        tick();
        hx_a = fx_a;
        hy_a = fy_a;
        spawn_a = 1'b1;
        @(negedge clk);
        check("a_hit_spawn_eaten", eaten_a, 1);
        tick();
        spawn_a = 1'b1;
        @(negedge clk);
        check("a_draw_busy", busy_a, 1);
        check("a_draw_no_eaten", eaten_a, 0);
        tick();
        spawn_a = 1'b0;
        wait_valid(0, "a_hit_spawn_timeout");
        repeat (4) @(negedge clk);
        check("a_settled_valid", fv_a, 1);
        check("a_settled_busy", busy_a, 0);
        check("a_one_eaten", eaten_cnt_a - e0, 1);
        check("a_one_draw", draw_ep_a - d0, 1);
        check_food_a();

        // 6: reset in the middle of DRAW
        e0 = eaten_cnt_a;
        pulse_spawn(0);
        @(negedge clk);
        check("a_pre_rst_busy", busy_a, 1);
        #2;
        rst_a = 1'b0;
        #1;
        check("a_mid_rst_x", fx_a, 0);
        check("a_mid_rst_y", fy_a, 0);
        check("a_mid_rst_valid", fv_a, 0);
        check("a_mid_rst_busy", busy_a, 0);
        check("a_mid_rst_eaten", eaten_a, 0);
        check("a_mid_rst_state", st_a, EMPTY);
        check("a_mid_rst_lfsr", lfsr_a, SEED);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("a_post_rst_state", st_a, EMPTY);
        check("a_post_rst_valid", fv_a, 0);
        check("a_post_rst_no_eaten", eaten_cnt_a - e0, 0);

        // 3: tiny 3x2 grid, head at (0,0)
        seen = '0;
        for (int i = 0; i < 1000; i++) begin
            pulse_spawn(1);
            wait_valid(1, "b_valid_timeout");
            col = int'(fx_b) / 10;
            row = int'(fy_b) / 10;
            ok  = (fx_b % 10 == 0) && (fy_b % 10 == 0) && (col < 3) && (row < 2) && !(col == 0 && row == 0);
            check("b_cell_ok", ok, 1);
            if (col < 3 && row < 2) seen[row * 3 + col] = 1'b1;
        end
        check("b_all_free_seen", seen, 6'b111110);

        // fallback walk: table vectors first
        for (int i = 0; i < 4; i++) begin
            spawn_c_expect(vecs[i].hx, vecs[i].hy, vecs[i].ex, vecs[i].ey);
        end

        // continue the walk with head at (0,0) up to the last cell
        cur_c = 5;
        cur_r = 0;
        while (!(cur_c == 63 && cur_r == 47)) begin
            adv_cell(cur_c, cur_r);
            if (cur_c == 0 && cur_r == 0) adv_cell(cur_c, cur_r);
            spawn_c_expect(0, 0, cur_c * 10, cur_r * 10);
        end
        check("c_at_last_x", fx_c, 630);
        check("c_at_last_y", fy_c, 470);

        // 4: wrap from (630,470) lands on the head, so food goes to (10,0)
        spawn_c_expect(0, 0, 10, 0);
        check("c_wrap_x", fx_c, 10);
        check("c_wrap_y", fy_c, 0);

        // eaten on the fallback instance: next cell is (20,0)
        tick();
        hx_c = 10'd10;
        hy_c = 9'd0;
        exp_q.push_back({10'd20, 9'd0});
        @(negedge clk);
        check("c_eaten_pulse", eaten_c, 1);
        @(negedge clk);
        check("c_eaten_drop", eaten_c, 0);
        check("c_valid_drop", fv_c, 0);
        check("c_hold_old_x", fx_c, 10);
        wait_valid(2, "c_eat_respawn_timeout");
        repeat (2) @(negedge clk);
        check("c_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit for the whole run.
    initial begin
        #3000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
